// File: rtl/bithub_link_pkg.sv
// Shared types and helpers for the secure-link wrapper: session state encoding,
// header layout and saturating telemetry arithmetic.
package bithub_link_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StId     = 3'd1,
    StKey    = 3'd2,
    StActive = 3'd3,
    StRekey  = 3'd4
  } sess_state_t;

  // The sequence number occupies the low bits of the header beat; upper bits are zero.
  localparam int unsigned HdrSeqLsb = 0;

  localparam int unsigned TlmW = 32;

  function automatic logic [TlmW-1:0] sat_add(input logic [TlmW-1:0] cnt,
                                              input logic [1:0]      inc);
    logic [TlmW:0] sum;
    sum = {1'b0, cnt} + {{(TlmW - 1){1'b0}}, inc};
    return sum[TlmW] ? {TlmW{1'b1}} : sum[TlmW-1:0];
  endfunction

endpackage

// File: rtl/bithub_replay_window.sv
// Sliding-window anti-replay tracker: highest accepted sequence number plus a bitmap
// of recently seen sequence numbers below it.
module bithub_replay_window #(
  parameter int unsigned SEQ_W = 32,
  parameter int unsigned WIN   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [SEQ_W-1:0] check_seq_i,
  output logic             check_ok_o,
  input  logic             update_i,
  input  logic             clear_i
);

  logic [SEQ_W-1:0] top_q, top_d;
  logic [WIN-1:0]   bmp_q, bmp_d;
  logic [WIN-1:0]   bmp_shr;
  logic [SEQ_W-1:0] fwd, back;
  logic             ahead, in_win;

  always_comb begin
    ahead      = check_seq_i > top_q;
    fwd        = check_seq_i - top_q;
    back       = top_q - check_seq_i;
    in_win     = !ahead && (back < SEQ_W'(WIN));
    bmp_shr    = bmp_q >> back;
    // Sequence 0 is never valid, even right after a clear when top is 0.
    check_ok_o = (check_seq_i != '0) && (ahead || (in_win && !bmp_shr[0]));

    top_d = top_q;
    bmp_d = bmp_q;
    if (clear_i) begin
      top_d = '0;
      bmp_d = '0;
    end else if (update_i && check_ok_o) begin
      if (ahead) begin
        // Shifting by >= WIN empties the map, which gives the min(delta, WIN) behaviour.
        top_d = check_seq_i;
        bmp_d = (bmp_q << fwd) | WIN'(1);
      end else begin
        bmp_d = bmp_q | (WIN'(1) << back);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      top_q <= '0;
      bmp_q <= '0;
    end else begin
      top_q <= top_d;
      bmp_q <= bmp_d;
    end
  end

endmodule

// File: rtl/bithub_secure_link_v2.sv
// Secure-link wrapper: session FSM, TX sequence-header insertion, RX anti-replay
// filtering, packet-boundary throttling, kill-switch and saturating telemetry.
module bithub_secure_link_v2
  import bithub_link_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned SEQ_W      = 32,
  parameter int unsigned WIN        = 32,
  parameter int unsigned REKEY_PKTS = 2 ** 20
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] app_tx_tdata_i,
  input  logic              app_tx_tvalid_i,
  input  logic              app_tx_tlast_i,
  output logic              app_tx_tready_o,
  output logic [DATA_W-1:0] app_rx_tdata_o,
  output logic              app_rx_tvalid_o,
  output logic              app_rx_tlast_o,
  input  logic              app_rx_tready_i,
  output logic [DATA_W-1:0] net_tx_tdata_o,
  output logic              net_tx_tvalid_o,
  output logic              net_tx_tlast_o,
  input  logic              net_tx_tready_i,
  input  logic [DATA_W-1:0] net_rx_tdata_i,
  input  logic              net_rx_tvalid_i,
  input  logic              net_rx_tlast_i,
  output logic              net_rx_tready_o,
  input  logic              gov_enable_i,
  input  logic              bci_pause_i,
  input  logic              maint_window_i,
  output logic              id_req_o,
  input  logic              id_ok_i,
  output logic              key_req_o,
  output logic              key_inval_o,
  input  logic              key_ok_i,
  output logic [2:0]        sess_state_o,
  output logic [TlmW-1:0]   tlm_tx_pkts_o,
  output logic [TlmW-1:0]   tlm_rx_pkts_o,
  output logic [TlmW-1:0]   tlm_replays_blocked_o,
  output logic [TlmW-1:0]   tlm_auth_fail_o,
  output logic [TlmW-1:0]   tlm_aborts_o
);

  // tx_seq equals (packets sent under this key + 1) at each payload tlast.
  localparam logic [SEQ_W-1:0] RekeySeq = SEQ_W'(REKEY_PKTS) + SEQ_W'(1);

  sess_state_t      state_q, state_d;
  logic             id_req_q, key_req_q, key_inval_q;
  logic [SEQ_W-1:0] tx_seq_q, tx_seq_d, tx_seq_nxt;
  logic             tx_in_pkt_q, tx_in_pkt_d, tx_pkt_nxt;
  logic             hdr_pend_q, hdr_pend_d, hdr_pend_nxt;
  logic             rx_in_pkt_q, rx_in_pkt_d, rx_pkt_nxt;
  logic             rx_acc_q, rx_acc_d;
  logic             auth_q, auth_cond;
  logic [TlmW-1:0]  tx_pkts_q, rx_pkts_q, replays_q, auth_fail_q, aborts_q;

  logic active, throttle, enter_active, leave_active, rekey_hit;
  logic tx_done, rx_done, rx_reject, win_ok, win_update, tx_abort, rx_abort;

  assign active   = (state_q == StActive);
  assign throttle = bci_pause_i & ~maint_window_i;

  // TX: one header beat carrying tx_seq, then payload passes straight through.
  always_comb begin
    app_tx_tready_o = 1'b0;
    net_tx_tvalid_o = 1'b0;
    net_tx_tdata_o  = '0;
    net_tx_tlast_o  = 1'b0;
    tx_pkt_nxt      = tx_in_pkt_q;
    hdr_pend_nxt    = hdr_pend_q;
    tx_seq_nxt      = tx_seq_q;
    tx_done         = 1'b0;
    if (active) begin
      if (tx_in_pkt_q) begin
        net_tx_tvalid_o = app_tx_tvalid_i;
        net_tx_tdata_o  = app_tx_tdata_i;
        net_tx_tlast_o  = app_tx_tlast_i;
        app_tx_tready_o = net_tx_tready_i;
        if (app_tx_tvalid_i && net_tx_tready_i && app_tx_tlast_i) begin
          tx_pkt_nxt = 1'b0;
          tx_done    = 1'b1;
        end
      end else begin
        // A header already offered stays valid even if throttle rises meanwhile.
        net_tx_tvalid_o = app_tx_tvalid_i & (~throttle | hdr_pend_q);
        net_tx_tdata_o  = DATA_W'(tx_seq_q) << HdrSeqLsb;
        hdr_pend_nxt    = net_tx_tvalid_o & ~net_tx_tready_i;
        if (net_tx_tvalid_o && net_tx_tready_i) begin
          tx_pkt_nxt = 1'b1;
          tx_seq_nxt = tx_seq_q + SEQ_W'(1);
        end
      end
    end
  end

  // RX: header beat is consumed and judged; payload is forwarded or drained.
  always_comb begin
    net_rx_tready_o = 1'b0;
    app_rx_tvalid_o = 1'b0;
    app_rx_tlast_o  = 1'b0;
    app_rx_tdata_o  = net_rx_tdata_i;
    rx_pkt_nxt      = rx_in_pkt_q;
    rx_acc_d        = rx_acc_q;
    win_update      = 1'b0;
    rx_reject       = 1'b0;
    rx_done         = 1'b0;
    if (active) begin
      if (!rx_in_pkt_q) begin
        net_rx_tready_o = ~throttle;
        if (net_rx_tvalid_i && !throttle) begin
          if (net_rx_tlast_i) begin
            rx_reject = 1'b1;
          end else begin
            rx_pkt_nxt = 1'b1;
            rx_acc_d   = win_ok;
            win_update = win_ok;
            rx_reject  = ~win_ok;
          end
        end
      end else if (rx_acc_q) begin
        app_rx_tvalid_o = net_rx_tvalid_i;
        app_rx_tlast_o  = net_rx_tlast_i;
        net_rx_tready_o = app_rx_tready_i;
        if (net_rx_tvalid_i && app_rx_tready_i && net_rx_tlast_i) begin
          rx_pkt_nxt = 1'b0;
          rx_done    = 1'b1;
        end
      end else begin
        net_rx_tready_o = 1'b1;
        if (net_rx_tvalid_i && net_rx_tlast_i) begin
          rx_pkt_nxt = 1'b0;
        end
      end
    end
  end

  assign rekey_hit = tx_done && (tx_seq_q == RekeySeq);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (gov_enable_i) state_d = StId;
      StId:     if (id_ok_i) state_d = StKey;
      StKey:    if (key_ok_i) state_d = StActive;
      StActive: begin
        if (!id_ok_i) state_d = StId;
        else if (rekey_hit) state_d = StRekey;
      end
      StRekey:  if (!key_ok_i) state_d = StKey;
      default:  state_d = StIdle;
    endcase
    if (!gov_enable_i) state_d = StIdle;
  end

  assign enter_active = (state_d == StActive) && !active;
  assign leave_active = active && (state_d != StActive);
  assign tx_abort     = leave_active & tx_pkt_nxt;
  assign rx_abort     = leave_active & rx_pkt_nxt;
  assign tx_in_pkt_d  = tx_pkt_nxt & (state_d == StActive);
  assign hdr_pend_d   = hdr_pend_nxt & (state_d == StActive);
  assign rx_in_pkt_d  = rx_pkt_nxt & (state_d == StActive);
  assign tx_seq_d     = enter_active ? SEQ_W'(1) : tx_seq_nxt;
  assign auth_cond    = !active && (app_tx_tvalid_i || net_rx_tvalid_i);

  bithub_replay_window #(
    .SEQ_W(SEQ_W),
    .WIN  (WIN)
  ) u_replay_window (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .check_seq_i(net_rx_tdata_i[HdrSeqLsb +: SEQ_W]),
    .check_ok_o (win_ok),
    .update_i   (win_update),
    .clear_i    (enter_active)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      id_req_q    <= 1'b0;
      key_req_q   <= 1'b0;
      key_inval_q <= 1'b0;
      tx_seq_q    <= '0;
      tx_in_pkt_q <= 1'b0;
      hdr_pend_q  <= 1'b0;
      rx_in_pkt_q <= 1'b0;
      rx_acc_q    <= 1'b0;
      auth_q      <= 1'b0;
      tx_pkts_q   <= '0;
      rx_pkts_q   <= '0;
      replays_q   <= '0;
      auth_fail_q <= '0;
      aborts_q    <= '0;
    end else begin
      state_q     <= state_d;
      id_req_q    <= (state_d == StId);
      key_req_q   <= (state_d == StKey);
      key_inval_q <= (state_d == StRekey);
      tx_seq_q    <= tx_seq_d;
      tx_in_pkt_q <= tx_in_pkt_d;
      hdr_pend_q  <= hdr_pend_d;
      rx_in_pkt_q <= rx_in_pkt_d;
      rx_acc_q    <= rx_acc_d;
      auth_q      <= auth_cond;
      if (tx_done) tx_pkts_q <= sat_add(tx_pkts_q, 2'd1);
      if (rx_done) rx_pkts_q <= sat_add(rx_pkts_q, 2'd1);
      if (rx_reject) replays_q <= sat_add(replays_q, 2'd1);
      if (auth_cond && !auth_q) auth_fail_q <= sat_add(auth_fail_q, 2'd1);
      if (tx_abort || rx_abort) begin
        aborts_q <= sat_add(aborts_q, {1'b0, tx_abort} + {1'b0, rx_abort});
      end
    end
  end

  assign sess_state_o          = state_q;
  assign id_req_o              = id_req_q;
  assign key_req_o             = key_req_q;
  assign key_inval_o           = key_inval_q;
  assign tlm_tx_pkts_o         = tx_pkts_q;
  assign tlm_rx_pkts_o         = rx_pkts_q;
  assign tlm_replays_blocked_o = replays_q;
  assign tlm_auth_fail_o       = auth_fail_q;
  assign tlm_aborts_o          = aborts_q;

endmodule
